// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: bundles the stopwatch controller's button inputs,
// timebase tick and control/status outputs.
//   master : board/bench side, drives buttons and tick, observes outputs
//   slave  : controller side, consumes buttons and tick, drives outputs
interface stopwatch_ctrl_if;
    logic       btn_start_stop;
    logic       btn_lap;
    logic       btn_clear;
    logic       tick;
    logic       run;
    logic       timer_clear;
    logic       lap_clear;
    logic       lap_capture;
    logic [1:0] display_select;
    logic [1:0] state;

    modport master (
        output btn_start_stop, btn_lap, btn_clear, tick,
        input  run, timer_clear, lap_clear, lap_capture, display_select, state
    );

    modport slave (
        input  btn_start_stop, btn_lap, btn_clear, tick,
        output run, timer_clear, lap_clear, lap_capture, display_select, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: synchronizes and debounces the three stopwatch buttons and
// sequences them through an IDLE/RUNNING/LAP_VIEW/STOPPED machine.
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : slave side of stopwatch_ctrl_if
//            in : btn_start_stop, btn_lap, btn_clear (raw, async), tick
//            out: run, timer_clear, lap_clear, lap_capture (1-clk pulses),
//                 display_select (00 live/01 lap1/10 lap2), state
// Every output comes straight from a flop.

// One button lane: 2-flop synchronizer, debounce counter, registered
// rising-edge pulse.
module stopwatch_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          db, db_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync <= '0;
            db   <= 1'b0;
            db_q <= 1'b0;
            cnt  <= '0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            db_q <= db;
            // Registered edge keeps the FSM input a flop, giving the
            // fixed DEBOUNCE_CYCLES+3 press-to-output latency.
            rise <= db & ~db_q;
            if (sync[1] != db) begin
                if (cnt == LAST) begin
                    db  <= sync[1];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;   // bounce back to accepted level restarts the count
            end
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LAP_VIEW_TICKS  = 30
) (
    input  logic             clk,
    input  logic             resetn,
    stopwatch_ctrl_if.slave  bus
);
    localparam int TW = $clog2(LAP_VIEW_TICKS + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(LAP_VIEW_TICKS);
    localparam logic [TW-1:0] TMO_LAST = TW'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUNNING  = 2'b01,
        LAP_VIEW = 2'b10,
        STOPPED  = 2'b11
    } state_t;

    // Button lanes: [0] start_stop, [1] lap, [2] clear
    logic [2:0] raw, rise;
    assign raw = {bus.btn_clear, bus.btn_lap, bus.btn_start_stop};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .resetn (resetn),
            .raw    (raw[i]),
            .rise   (rise[i])
        );
    end

    // One event per cycle: start_stop > clear > lap; losers are dropped.
    logic sel_ss, sel_clr, sel_lap;
    assign sel_ss  = rise[0];
    assign sel_clr = rise[2] & ~rise[0];
    assign sel_lap = rise[1] & ~rise[0] & ~rise[2];

    state_t        st;
    logic          run_q, tclr_q, lclr_q, cap_q;
    logic [1:0]    disp_q;
    logic [TW-1:0] tmo;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st     <= IDLE;
            run_q  <= 1'b0;
            tclr_q <= 1'b0;
            lclr_q <= 1'b0;
            cap_q  <= 1'b0;
            disp_q <= 2'b00;
            tmo    <= '0;
        end else begin
            tclr_q <= 1'b0;
            lclr_q <= 1'b0;
            cap_q  <= 1'b0;
            case (st)
                IDLE: begin
                    run_q  <= 1'b0;
                    disp_q <= 2'b00;
                    if (sel_ss) begin
                        st    <= RUNNING;
                        run_q <= 1'b1;
                    end else if (sel_clr) begin
                        tclr_q <= 1'b1;
                        lclr_q <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (sel_ss) begin
                        st    <= STOPPED;
                        run_q <= 1'b0;
                    end else if (sel_lap) begin
                        st     <= LAP_VIEW;
                        cap_q  <= 1'b1;
                        disp_q <= 2'b01;
                        tmo    <= TMO_LOAD;
                    end
                end
                LAP_VIEW: begin
                    // Loading happens on a lap edge, so a tick in that same
                    // cycle is never counted.
                    if (sel_ss) begin
                        st     <= STOPPED;
                        run_q  <= 1'b0;
                        disp_q <= 2'b00;
                    end else if (sel_lap) begin
                        cap_q <= 1'b1;
                        tmo   <= TMO_LOAD;
                    end else if (bus.tick) begin
                        tmo <= tmo - 1'b1;
                        if (tmo == TMO_LAST) begin
                            st     <= RUNNING;
                            disp_q <= 2'b00;
                        end
                    end
                end
                STOPPED: begin
                    if (sel_ss) begin
                        st     <= RUNNING;
                        run_q  <= 1'b1;
                        disp_q <= 2'b00;
                    end else if (sel_clr) begin
                        st     <= IDLE;
                        tclr_q <= 1'b1;
                        lclr_q <= 1'b1;
                        disp_q <= 2'b00;
                    end else if (sel_lap) begin
                        disp_q <= (disp_q == 2'b10) ? 2'b00 : disp_q + 2'b01;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.run            = run_q;
    assign bus.timer_clear    = tclr_q;
    assign bus.lap_clear      = lclr_q;
    assign bus.lap_capture    = cap_q;
    assign bus.display_select = disp_q;
    assign bus.state          = st;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, LAP_VIEW_TICKS=3.
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_cap = 0, n_tclr = 0, n_lclr = 0, n_both = 0;
    int   cap0, tclr0, lclr0, both0;

    stopwatch_ctrl_if bus();

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .LAP_VIEW_TICKS(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled 2 ns after each rising edge.
    always @(posedge clk) begin
        #2;
        if (bus.lap_capture === 1'b1) n_cap++;
        if (bus.timer_clear === 1'b1) n_tclr++;
        if (bus.lap_clear === 1'b1) n_lclr++;
        if (bus.timer_clear === 1'b1 && bus.lap_clear === 1'b1) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic snap();
        cap0 = n_cap; tclr0 = n_tclr; lclr0 = n_lclr; both0 = n_both;
    endtask

    // m = {clear, lap, start_stop}; held `hold` clocks, then released and
    // given time for the release to debounce.
    task automatic press(input logic [2:0] m, input int hold);
        bus.btn_start_stop = m[0];
        bus.btn_lap        = m[1];
        bus.btn_clear      = m[2];
        repeat (hold) @(negedge clk);
        bus.btn_start_stop = 1'b0;
        bus.btn_lap        = 1'b0;
        bus.btn_clear      = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic tick1();
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic [1:0] st, input logic rn, input logic [1:0] ds);
        check({tag, "_state"}, 32'(bus.state), 32'(st));
        check({tag, "_run"}, 32'(bus.run), 32'(rn));
        check({tag, "_disp"}, 32'(bus.display_select), 32'(ds));
    endtask

    initial begin
        bus.btn_start_stop = 1'b0;
        bus.btn_lap        = 1'b0;
        bus.btn_clear      = 1'b0;
        bus.tick           = 1'b0;
        repeat (2) @(negedge clk);
        check_outs("rst", 2'b00, 1'b0, 2'b00);
        check("rst_pulses", 32'({bus.timer_clear, bus.lap_clear, bus.lap_capture}), 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        // Latency: pressed before edge 0, run rises after edge 7 only.
        snap();
        bus.btn_start_stop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 6) check("lat_run_e6", 32'(bus.run), 32'h0);
            if (i == 7) check("lat_run_e7", 32'(bus.run), 32'h1);
        end
        bus.btn_start_stop = 1'b0;
        repeat (10) @(negedge clk);
        check_outs("start", 2'b01, 1'b1, 2'b00);
        check("start_nopulse", 32'((n_cap - cap0) + (n_tclr - tclr0) + (n_lclr - lclr0)), 32'h0);
        press(3'b001, 10);
        check_outs("stop", 2'b11, 1'b0, 2'b00);

        // Bouncing start_stop never settles long enough.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.btn_start_stop = ~bus.btn_start_stop;
            repeat (2) @(negedge clk);
        end
        bus.btn_start_stop = 1'b0;
        repeat (12) @(negedge clk);
        check_outs("bounce", 2'b00, 1'b0, 2'b00);

        // Lap capture and view timeout.
        do_reset();
        press(3'b001, 10);
        snap();
        press(3'b010, 10);
        check("lap1_cap", 32'(n_cap - cap0), 32'h1);
        check_outs("lap1", 2'b10, 1'b1, 2'b01);
        tick1(); tick1();
        check("lap1_t2_state", 32'(bus.state), 32'h2);
        tick1();
        check_outs("lap1_exit", 2'b01, 1'b1, 2'b00);
        snap();
        press(3'b010, 10);
        tick1(); tick1();
        press(3'b010, 10);
        check("lap2_cap", 32'(n_cap - cap0), 32'h2);
        tick1(); tick1();
        check("lap2_t2_state", 32'(bus.state), 32'h2);
        tick1();
        check_outs("lap2_exit", 2'b01, 1'b1, 2'b00);

        // Stopped recall cycle, then clear.
        press(3'b001, 10);
        check("stopped", 32'(bus.state), 32'h3);
        snap();
        press(3'b010, 10); check("recall1", 32'(bus.display_select), 32'h1);
        press(3'b010, 10); check("recall2", 32'(bus.display_select), 32'h2);
        press(3'b010, 10); check("recall3", 32'(bus.display_select), 32'h0);
        press(3'b010, 10); check("recall4", 32'(bus.display_select), 32'h1);
        check("recall_nocap", 32'(n_cap - cap0), 32'h0);
        press(3'b100, 10);
        check("clr_both", 32'(n_both - both0), 32'h1);
        check("clr_tclr", 32'(n_tclr - tclr0), 32'h1);
        check("clr_lclr", 32'(n_lclr - lclr0), 32'h1);
        check_outs("clr", 2'b00, 1'b0, 2'b00);

        // Clear ignored while running; start_stop beats clear in STOPPED.
        press(3'b001, 10);
        snap();
        press(3'b100, 10);
        check("runclr_tclr", 32'(n_tclr - tclr0), 32'h0);
        check("runclr_state", 32'(bus.state), 32'h1);
        press(3'b001, 10);
        check("prio_stopped", 32'(bus.state), 32'h3);
        press(3'b101, 10);
        check("prio_state", 32'(bus.state), 32'h1);
        check("prio_tclr", 32'(n_tclr - tclr0), 32'h0);

        // Reset while lap view timeout is pending.
        press(3'b010, 10);
        tick1();
        check("prerst_state", 32'(bus.state), 32'h2);
        resetn = 1'b0;
        #1;
        check_outs("async_rst", 2'b00, 1'b0, 2'b00);
        check("async_rst_pulses", 32'({bus.timer_clear, bus.lap_clear, bus.lap_capture}), 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        repeat (5) tick1();
        check_outs("post_rst", 2'b00, 1'b0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
